// File: rtl/eva_ctr_bank.sv
// rtl/eva_ctr_bank.sv - EVA per-line age/class tracker with R/NR hit and eviction histograms and snapshot publish
module eva_ctr_bank #(
    parameter int LINES  = 32,
    parameter int ADDR_W = 5,
    parameter int K      = 3,
    parameter int J      = 2,
    parameter int CTR_W  = 10,
    parameter int ACC_W  = 11
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        re,
    input  logic                        we,
    input  logic                        hit,
    input  logic                        miss,
    input  logic                        evict_data,
    input  logic [ADDR_W-1:0]           access_addr,
    input  logic [ADDR_W-1:0]           write_addr,
    input  logic [ADDR_W-1:0]           evict_addr,
    input  logic                        snap_ready,
    output logic                        snap_valid,
    output logic [(1<<K)*CTR_W-1:0]     snap_hit_r_1d,
    output logic [(1<<K)*CTR_W-1:0]     snap_hit_nr_1d,
    output logic [(1<<K)*CTR_W-1:0]     snap_ev_r_1d,
    output logic [(1<<K)*CTR_W-1:0]     snap_ev_nr_1d,
    output logic [LINES*K-1:0]          age_1d,
    output logic [LINES-1:0]            class_1d,
    output logic                        overrun
);
    localparam int N   = 1 << K;
    localparam int AW1 = ADDR_W + 1;

    typedef enum logic {IDLE, PUBLISH} state_t;

    state_t             state;
    logic [J-1:0]       gran;
    logic [ACC_W-1:0]   acc;
    logic [K-1:0]       age [LINES];
    logic [LINES-1:0]   cls;

    logic [CTR_W-1:0]   hit_r [N];
    logic [CTR_W-1:0]   hit_nr [N];
    logic [CTR_W-1:0]   ev_r [N];
    logic [CTR_W-1:0]   ev_nr [N];
    logic [CTR_W-1:0]   s_hit_r [N];
    logic [CTR_W-1:0]   s_hit_nr [N];
    logic [CTR_W-1:0]   s_ev_r [N];
    logic [CTR_W-1:0]   s_ev_nr [N];

    logic [CTR_W-1:0]   nx_hit_r [N];
    logic [CTR_W-1:0]   nx_hit_nr [N];
    logic [CTR_W-1:0]   nx_ev_r [N];
    logic [CTR_W-1:0]   nx_ev_nr [N];
    logic [K-1:0]       nx_age [LINES];
    logic [LINES-1:0]   nx_cls;

    logic               tick, expire;
    logic               hit_ok, we_ok, ev_ok;
    logic [K-1:0]       hit_age, ev_age;
    logic               hit_cls, ev_cls;

    // miss carries no state of its own; reads tick ages through re
    logic unused;
    assign unused = miss;

    function automatic logic [CTR_W-1:0] sat_inc(input logic [CTR_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + CTR_W'(1) : v;
    endfunction

    always_comb begin
        tick    = re && (gran == '1);
        expire  = re && (acc == '1);
        hit_ok  = ({1'b0, access_addr} < AW1'(LINES));
        we_ok   = ({1'b0, write_addr}  < AW1'(LINES));
        ev_ok   = ({1'b0, evict_addr}  < AW1'(LINES));
        hit_age = '0;
        hit_cls = 1'b0;
        ev_age  = '0;
        ev_cls  = 1'b0;
        // out-of-range lines fall into NR bin 0
        if (hit_ok) begin
            hit_age = age[access_addr];
            hit_cls = cls[access_addr];
        end
        if (ev_ok) begin
            ev_age = age[evict_addr];
            ev_cls = cls[evict_addr];
        end
        for (int b = 0; b < N; b++) begin
            nx_hit_r[b]  = sat_inc(hit_r[b],  hit && hit_cls  && (hit_age == K'(b)));
            nx_hit_nr[b] = sat_inc(hit_nr[b], hit && !hit_cls && (hit_age == K'(b)));
            nx_ev_r[b]   = sat_inc(ev_r[b],   evict_data && ev_cls  && (ev_age == K'(b)));
            nx_ev_nr[b]  = sat_inc(ev_nr[b],  evict_data && !ev_cls && (ev_age == K'(b)));
        end
        nx_cls = cls;
        for (int l = 0; l < LINES; l++) begin
            nx_age[l] = age[l];
            if (tick && (age[l] != '1))
                nx_age[l] = age[l] + K'(1);
            if (hit && hit_ok && (access_addr == ADDR_W'(l))) begin
                nx_age[l] = '0;
                nx_cls[l] = 1'b1;
            end
            // a fill on the same line wins over a concurrent hit
            if (we && we_ok && (write_addr == ADDR_W'(l))) begin
                nx_age[l] = '0;
                nx_cls[l] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            snap_valid <= 1'b0;
            overrun    <= 1'b0;
            gran       <= '0;
            acc        <= '0;
            cls        <= '0;
            for (int l = 0; l < LINES; l++)
                age[l] <= '0;
            for (int b = 0; b < N; b++) begin
                hit_r[b]    <= '0;
                hit_nr[b]   <= '0;
                ev_r[b]     <= '0;
                ev_nr[b]    <= '0;
                s_hit_r[b]  <= '0;
                s_hit_nr[b] <= '0;
                s_ev_r[b]   <= '0;
                s_ev_nr[b]  <= '0;
            end
        end else begin
            if (re) begin
                gran <= gran + J'(1);
                acc  <= acc + ACC_W'(1);
            end
            cls <= nx_cls;
            for (int l = 0; l < LINES; l++)
                age[l] <= nx_age[l];
            for (int b = 0; b < N; b++) begin
                hit_r[b]  <= nx_hit_r[b];
                hit_nr[b] <= nx_hit_nr[b];
                ev_r[b]   <= nx_ev_r[b];
                ev_nr[b]  <= nx_ev_nr[b];
            end
            case (state)
                IDLE: begin
                    if (expire) begin
                        for (int b = 0; b < N; b++) begin
                            s_hit_r[b]  <= nx_hit_r[b];
                            s_hit_nr[b] <= nx_hit_nr[b];
                            s_ev_r[b]   <= nx_ev_r[b];
                            s_ev_nr[b]  <= nx_ev_nr[b];
                            hit_r[b]    <= nx_hit_r[b]  >> 1;
                            hit_nr[b]   <= nx_hit_nr[b] >> 1;
                            ev_r[b]     <= nx_ev_r[b]   >> 1;
                            ev_nr[b]    <= nx_ev_nr[b]  >> 1;
                        end
                        state      <= PUBLISH;
                        snap_valid <= 1'b1;
                    end
                end
                PUBLISH: begin
                    // an interval expiring here is dropped entirely
                    if (expire)
                        overrun <= 1'b1;
                    if (snap_ready) begin
                        state      <= IDLE;
                        snap_valid <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    snap_valid <= 1'b0;
                end
            endcase
        end
    end

    assign class_1d = cls;

    for (genvar g = 0; g < N; g++) begin : g_snap
        assign snap_hit_r_1d[g*CTR_W +: CTR_W]  = s_hit_r[g];
        assign snap_hit_nr_1d[g*CTR_W +: CTR_W] = s_hit_nr[g];
        assign snap_ev_r_1d[g*CTR_W +: CTR_W]   = s_ev_r[g];
        assign snap_ev_nr_1d[g*CTR_W +: CTR_W]  = s_ev_nr[g];
    end

    for (genvar g = 0; g < LINES; g++) begin : g_age
        assign age_1d[g*K +: K] = age[g];
    end
endmodule

// File: tb/tb_eva_ctr_bank.sv
// tb/tb_eva_ctr_bank.sv - scoreboard bench for eva_ctr_bank with a behavioural reference model
module tb_eva_ctr_bank;
    localparam int LINES = 32, ADDR_W = 5, K = 3, J = 2, CTR_W = 4, ACC_W = 3;
    localparam int N = 8, HW = N * CTR_W;
    localparam int AMAX = 7, CMAX = 15, ACC_LEN = 8, GRAN_LEN = 4;

    logic clk = 1'b0, rst = 1'b1;
    logic re = 0, we = 0, hit = 0, miss = 0, evict_data = 0, snap_ready = 0;
    logic [ADDR_W-1:0] access_addr = '0, write_addr = '0, evict_addr = '0;
    logic snap_valid, overrun;
    logic [HW-1:0] snap_hit_r_1d, snap_hit_nr_1d, snap_ev_r_1d, snap_ev_nr_1d;
    logic [LINES*K-1:0] age_1d;
    logic [LINES-1:0] class_1d;

    eva_ctr_bank #(.LINES(LINES), .ADDR_W(ADDR_W), .K(K), .J(J), .CTR_W(CTR_W), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst), .re(re), .we(we), .hit(hit), .miss(miss), .evict_data(evict_data),
        .access_addr(access_addr), .write_addr(write_addr), .evict_addr(evict_addr),
        .snap_ready(snap_ready), .snap_valid(snap_valid),
        .snap_hit_r_1d(snap_hit_r_1d), .snap_hit_nr_1d(snap_hit_nr_1d),
        .snap_ev_r_1d(snap_ev_r_1d), .snap_ev_nr_1d(snap_ev_nr_1d),
        .age_1d(age_1d), .class_1d(class_1d), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [HW-1:0] hr;
        logic [HW-1:0] hnr;
        logic [HW-1:0] er;
        logic [HW-1:0] enr;
    } snap_t;

    snap_t exp_q[$];
    snap_t cur_exp = '0;
    int m_age [LINES];
    bit m_cls [LINES];
    int m_h [4][N];   // 0 hit_r, 1 hit_nr, 2 ev_r, 3 ev_nr
    int m_acc, m_gran;
    bit m_pub, m_ovr;
    int checks = 0, errors = 0;
    bit prev_sv = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic snap_t pack_model();
        snap_t r;
        for (int b = 0; b < N; b++) begin
            r.hr[b*CTR_W +: CTR_W]  = CTR_W'(m_h[0][b]);
            r.hnr[b*CTR_W +: CTR_W] = CTR_W'(m_h[1][b]);
            r.er[b*CTR_W +: CTR_W]  = CTR_W'(m_h[2][b]);
            r.enr[b*CTR_W +: CTR_W] = CTR_W'(m_h[3][b]);
        end
        return r;
    endfunction

    function automatic logic [LINES*K-1:0] ages_vec();
        logic [LINES*K-1:0] v;
        for (int l = 0; l < LINES; l++) v[l*K +: K] = K'(m_age[l]);
        return v;
    endfunction

    function automatic logic [LINES-1:0] cls_vec();
        logic [LINES-1:0] v;
        for (int l = 0; l < LINES; l++) v[l] = m_cls[l];
        return v;
    endfunction

    task automatic model_reset();
        for (int l = 0; l < LINES; l++) begin m_age[l] = 0; m_cls[l] = 0; end
        for (int h = 0; h < 4; h++) for (int b = 0; b < N; b++) m_h[h][b] = 0;
        m_acc = 0; m_gran = 0; m_pub = 0; m_ovr = 0;
        exp_q.delete();
        cur_exp = '0;
    endtask

    // Applies the rules to the inputs present at the clock edge just taken
    task automatic model_step();
        int bin, idx;
        bit expire, tick;
        expire = re && (m_acc == ACC_LEN - 1);
        tick   = re && (m_gran == GRAN_LEN - 1);
        if (hit) begin
            bin = (access_addr < LINES) ? m_age[access_addr] : 0;
            idx = ((access_addr < LINES) && m_cls[access_addr]) ? 0 : 1;
            if (m_h[idx][bin] < CMAX) m_h[idx][bin]++;
        end
        if (evict_data) begin
            bin = (evict_addr < LINES) ? m_age[evict_addr] : 0;
            idx = ((evict_addr < LINES) && m_cls[evict_addr]) ? 2 : 3;
            if (m_h[idx][bin] < CMAX) m_h[idx][bin]++;
        end
        if (tick) for (int l = 0; l < LINES; l++) if (m_age[l] < AMAX) m_age[l]++;
        if (hit && access_addr < LINES) begin m_age[access_addr] = 0; m_cls[access_addr] = 1; end
        if (we && write_addr < LINES) begin m_age[write_addr] = 0; m_cls[write_addr] = 0; end
        if (re) begin
            m_acc  = (m_acc + 1) % ACC_LEN;
            m_gran = (m_gran + 1) % GRAN_LEN;
        end
        if (!m_pub) begin
            if (expire) begin
                exp_q.push_back(pack_model());
                for (int h = 0; h < 4; h++) for (int b = 0; b < N; b++) m_h[h][b] = m_h[h][b] / 2;
                m_pub = 1;
            end
        end else begin
            if (expire) m_ovr = 1;
            if (snap_ready) m_pub = 0;
        end
    endtask

    task automatic drive(input bit r, input bit w, input bit h, input bit e,
                         input int aa = 0, input int wa = 0, input int ea = 0);
        re = r; we = w; hit = h; evict_data = e; miss = r && !h;
        access_addr = ADDR_W'(aa); write_addr = ADDR_W'(wa); evict_addr = ADDR_W'(ea);
        @(posedge clk);
        model_step();
        #1;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_sv = 0;
        end else begin
            if (snap_valid && !prev_sv) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL snap_unexpected: got snap_valid=1 expected no pending snapshot");
                end else begin
                    cur_exp = exp_q.pop_front();
                end
            end
            chk("snap_valid", snap_valid, m_pub);
            chk("overrun", overrun, m_ovr);
            chk("age_1d", age_1d, ages_vec());
            chk("class_1d", class_1d, cls_vec());
            chk("snap_hit_r", snap_hit_r_1d, cur_exp.hr);
            chk("snap_hit_nr", snap_hit_nr_1d, cur_exp.hnr);
            chk("snap_ev_r", snap_ev_r_1d, cur_exp.er);
            chk("snap_ev_nr", snap_ev_nr_1d, cur_exp.enr);
            prev_sv = snap_valid;
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no finish expected finish within time budget");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 0;
        chk("reset_snap_valid", snap_valid, 0);
        chk("reset_overrun", overrun, 0);
        chk("reset_age", age_1d, 0);

        // reset and aging
        for (int i = 0; i < 8; i++) drive(1, 0, 0, 0, i);
        chk("t1_age_all_2", age_1d, {LINES{3'd2}});
        chk("t1_snap_valid", snap_valid, 1);
        chk("t1_snap_zero", snap_hit_nr_1d, 0);
        snap_ready = 1;
        drive(0, 0, 0, 0);

        // saturating age and reuse class
        repeat (40) drive(1, 0, 0, 0, 3);
        drive(1, 0, 1, 0, 3);
        chk("t2_age3", age_1d[3*K +: K], 0);
        chk("t2_cls3", class_1d[3], 1);
        drive(1, 0, 1, 0, 3);
        repeat (6) drive(1, 0, 0, 0, 3);
        chk("t2_snap_hit_nr", snap_hit_nr_1d, 32'h1000_0000);
        chk("t2_snap_hit_r", snap_hit_r_1d, 32'h0000_0001);

        // fill vs hit collision
        drive(0, 1, 1, 0, 5, 5);
        chk("t3_age5", age_1d[5*K +: K], 0);
        chk("t3_cls5", class_1d[5], 0);

        // saturation and decay
        drive(0, 1, 0, 0, 0, 0);
        repeat (20) drive(0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 16 && !m_pub; i++) drive(1, 0, 0, 0, 9);
        chk("t4_snap_ev_nr_sat", snap_ev_nr_1d, 32'h0000_000F);
        drive(0, 0, 0, 0);
        for (int i = 0; i < 16 && !m_pub; i++) drive(1, 0, 0, 0, 9);
        chk("t4_snap_ev_nr_decay", snap_ev_nr_1d, 32'h0000_0007);
        drive(0, 0, 0, 0);

        // handshake, overrun and reset
        snap_ready = 0;
        repeat (8) drive(1, 0, 0, 0, 9);
        chk("t5_snap_ev_nr", snap_ev_nr_1d, 32'h0000_0003);
        repeat (8) drive(1, 0, 0, 0, 9);
        chk("t5_overrun", overrun, 1);
        chk("t5_snap_held", snap_ev_nr_1d, 32'h0000_0003);
        chk("t5_valid_before", snap_valid, 1);
        snap_ready = 1;
        drive(0, 0, 0, 0);
        chk("t5_valid_drop", snap_valid, 0);
        chk("t5_overrun_sticky", overrun, 1);
        snap_ready = 0;
        for (int i = 0; i < 16 && !m_pub; i++) drive(1, 0, 0, 0, 9);
        chk("t5_valid_again", snap_valid, 1);
        rst = 1;
        #1;
        chk("t5_rst_valid", snap_valid, 0);
        chk("t5_rst_overrun", overrun, 0);
        chk("t5_rst_snap", snap_ev_nr_1d, 0);
        model_reset();
        @(posedge clk);
        #1 rst = 0;

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            bit r, h;
            snap_ready = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 9) < 7);
            h = r && ($urandom_range(0, 1) == 1);
            drive(r, $urandom_range(0, 4) == 0, h, $urandom_range(0, 4) == 0,
                  $urandom_range(0, LINES - 1), $urandom_range(0, LINES - 1), $urandom_range(0, LINES - 1));
        end
        snap_ready = 1;
        repeat (4) drive(0, 0, 0, 0);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/eva_ctr_bank.md
# eva_ctr_bank

Parametrised successor to the EVA replacement-statistics block. It tracks per-line age and reuse class, and accumulates per-age hit and eviction histograms for reused (R) and non-reused (NR) lines. Every 2^ACC_W read accesses it publishes a frozen snapshot of all histograms to the EVA rank engine over a valid/ready handshake, then decays the live counters by halving. It sits beside the cache tag CAM and is driven by the same delayed re/we/hit/miss/evict strobes.

## Interface

Parameters:

- LINES, 32: number of cache lines.
- ADDR_W, 5: line index width; must satisfy 2^ADDR_W ≥ LINES.
- K, 3: age width. Histogram depth is N = 2^K bins.
- J, 2: granularity counter width. Ages tick once every 2^J read accesses.
- CTR_W, 10: histogram counter width. Counters saturate at this width.
- ACC_W, 11: access counter width. A snapshot is taken every 2^ACC_W reads.

Ports:

- clk, in, 1: clock; all state updates on the rising edge.
- rst, in, 1: asynchronous, active-high reset.
- re, in, 1: qualified read access strobe.
- we, in, 1: line fill strobe.
- hit, in, 1: read hit strobe.
- miss, in, 1: read miss strobe (informational; does not tick ages).
- evict_data, in, 1: eviction strobe.
- access_addr, in, ADDR_W: line index for re/hit.
- write_addr, in, ADDR_W: line index for we.
- evict_addr, in, ADDR_W: line index for evict_data.
- snap_ready, in, 1: EVA engine accepts the snapshot.
- snap_valid, out, 1: snapshot buses are valid and stable.
- snap_hit_r_1d, snap_hit_nr_1d, snap_ev_r_1d, snap_ev_nr_1d, out, N*CTR_W each: snapshot histograms. Bin i occupies bits [i*CTR_W +: CTR_W].
- age_1d, out, LINES*K: live age per line.
- class_1d, out, LINES: live classification bit per line; 1 = reused.
- overrun, out, 1: sticky flag; set when an interval expires while snap_valid is high.

## Operation

- All registers reset to 0. snap_valid, overrun and every output bus are 0 out of reset.
- **Granularity and age:**
  - Each re increments a J-bit granularity counter.
  - On its wrap, i.e. re with counter = 2^J−1, every line's age increments, saturating at 2^K−1.
- **Age reset:** hit on access_addr, or we on write_addr, sets that line's age to 0. This reset overrides the global tick for that line in the same cycle.
- **Classification:**
  - hit sets class[access_addr] to 1.
  - we clears class[write_addr] to 0.
  - If hit and we target the same line in the same cycle, we wins: class 0, age 0.
- **Histograms:**
  - On hit, increment hit_{R|NR}[age] using the pre-update age and class of access_addr.
  - On evict_data, increment ev_{R|NR}[age] of evict_addr in the same way.
  - All increments saturate at 2^CTR_W−1.
  - hit and evict_data in the same cycle update their respective counters independently.
- **Access counter:** ACC_W bits, incremented on re. An interval expires on re with counter = 2^ACC_W−1; the counter then wraps to 0.
- **Snapshot state machine:**
  - States: IDLE, PUBLISH.
  - IDLE, interval expires: copy all live counters into the snapshot registers, including any increment from that same cycle. Decay the live counters to (value_including_increment >> 1). Go to PUBLISH.
  - PUBLISH: snap_valid = 1 and the snapshot registers are frozen. On snap_valid & snap_ready, return to IDLE.
  - PUBLISH, interval expires: set overrun, take no snapshot and perform no decay. overrun clears only on rst.
  - Interval expiry and handshake completion in the same cycle: the handshake completes, the state returns to IDLE, and overrun is set. The expired interval is lost.
- Addresses ≥ LINES are ignored for age and class updates. A hit or evict at such an address still increments bin 0 of the NR histogram.

## Timing

- Every live-state effect is visible on the outputs one cycle after the strobe edge.
- Snapshot latency: snap_valid rises on the cycle after the expiring re edge.
- The minimum snap_valid pulse is 1 cycle, when snap_ready is already held high.
- snap_valid falls on the cycle after the accepting edge.
- Asynchronous rst mid-PUBLISH drops snap_valid immediately and clears all state; no snapshot is delivered.

## Test plan

Use K=3, J=2, CTR_W=4, ACC_W=3 and LINES=32 unless stated.

- **Reset and aging:** rst, then 8 re with no hit. Required: all ages = 2, snap_valid rises the cycle after the 8th re, and all snapshot bins = 0.
- **Saturating age and reuse class:** 40 re on line 3, then hit on line 3. Required: hit_nr[7] = 1, then age[3] = 0 and class[3] = 1. A second hit on line 3 at age 0 gives hit_r[0] = 1.
- **Fill vs hit collision:** hit and we on line 5 in the same cycle. Required: class[5] = 0, age[5] = 0, and the hit is counted in the NR bin at line 5's old age.
- **Saturation and decay:** 20 evicts of line 0 at age 0 (NR), then complete an interval. Required: snapshot ev_nr[0] = 15 and live ev_nr[0] = 7.
- **Handshake, overrun and reset:**
  - Hold snap_ready = 0 across a second interval. Required: overrun = 1 and snapshot contents unchanged.
  - Raise snap_ready. Required: snap_valid drops one cycle later.
  - Assert rst while snap_valid = 1. Required: snap_valid = 0 immediately.
